// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gfx_pkg
// Description : Shared constants and types for the graphics frame register
//               bank: register address map, object register count, commit
//               FSM state encoding and the default chip-select value.
// Revision    : 1.0  initial release
// ============================================================================
package gfx_pkg;

    // Default bus chip-select value that addresses the frame register bank
    localparam logic [3:0] GFX_CS_DEFAULT   = 4'd2;

    // Number of object parameter registers (shadow/live pairs)
    localparam int         NUM_OBJ_REGS     = 10;

    // Register address map
    localparam logic [3:0] ADDR_PADDLE_1_X  = 4'd0;
    localparam logic [3:0] ADDR_PADDLE_1_Y  = 4'd1;
    localparam logic [3:0] ADDR_PADDLE_2_X  = 4'd2;
    localparam logic [3:0] ADDR_PADDLE_2_Y  = 4'd3;
    localparam logic [3:0] ADDR_BALL_X      = 4'd4;
    localparam logic [3:0] ADDR_BALL_Y      = 4'd5;
    localparam logic [3:0] ADDR_BALL_Z      = 4'd6;
    localparam logic [3:0] ADDR_P1_SCORE    = 4'd7;
    localparam logic [3:0] ADDR_P2_SCORE    = 4'd8;
    localparam logic [3:0] ADDR_GAME_STATE  = 4'd9;
    localparam logic [3:0] ADDR_COMMIT      = 4'd15;

    // Commit controller states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } gfx_state_e;

endpackage : gfx_pkg
`default_nettype wire

// File: rtl/gfx_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_shadow_reg
// Description : One shadow/live register pair. CPU writes land in the shadow
//               register; a commit enable copies the shadow value (as it
//               stood before the edge) into the live register.
// Revision    : 1.0  initial release
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset, clears both registers
//   wr_en_i      in   load wr_data_i into the shadow register
//   wr_data_i    in   shadow write data
//   commit_en_i  in   copy shadow register into live register
//   live_o       out  live register value
// ============================================================================
module gfx_shadow_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              commit_en_i,
    output logic [DATA_W-1:0] live_o
);

    logic [DATA_W-1:0] r_shadow_q;
    logic [DATA_W-1:0] r_live_q;

    // Both registers update on the same edge: the live copy takes the old
    // shadow value, so a write coinciding with a commit waits for the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_q <= '0;
            r_live_q   <= '0;
        end else begin
            if (wr_en_i) begin
                r_shadow_q <= wr_data_i;
            end
            if (commit_en_i) begin
                r_live_q <= r_shadow_q;
            end
        end
    end

    assign live_o = r_live_q;

endmodule : gfx_shadow_reg
`default_nettype wire

// File: rtl/gfx_frame_regs.sv
`default_nettype none
// ============================================================================
// Module      : gfx_frame_regs
// Description : Bus-side register bank with frame-synchronous commit. CPU
//               writes update shadow registers; a COMMIT write arms a
//               transfer of all shadow values to the live registers at the
//               next end-of-frame strobe, so renderers never see a mix of
//               old and new object state.
// Revision    : 1.0  initial release
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   chipselect      in   bus select, write when equal to GFX_CS
//   databus         in   write data
//   data_address    in   register index (0-9 objects, 15 commit)
//   frame_done      in   one-cycle end-of-frame pulse
//   paddle_*/ball_*/player_*_score/game_state  out  live object registers
//   commit_pending  out  commit armed
//   commit_pulse    out  one-cycle pulse after a commit edge
//   frame_count     out  wrapping count of frames since reset
// ============================================================================
module gfx_frame_regs
    import gfx_pkg::*;
#(
    parameter logic [3:0] GFX_CS = GFX_CS_DEFAULT,
    parameter int         DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        chipselect,
    input  logic [DATA_W-1:0] databus,
    input  logic [3:0]        data_address,
    input  logic              frame_done,
    output logic [DATA_W-1:0] paddle_1_x,
    output logic [DATA_W-1:0] paddle_1_y,
    output logic [DATA_W-1:0] paddle_2_x,
    output logic [DATA_W-1:0] paddle_2_y,
    output logic [DATA_W-1:0] ball_x,
    output logic [DATA_W-1:0] ball_y,
    output logic [DATA_W-1:0] ball_z,
    output logic [DATA_W-1:0] player_1_score,
    output logic [DATA_W-1:0] player_2_score,
    output logic [DATA_W-1:0] game_state,
    output logic              commit_pending,
    output logic              commit_pulse,
    output logic [DATA_W-1:0] frame_count
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_bus_wr;
    logic w_commit_wr;
    logic w_commit_en;

    assign w_bus_wr    = (chipselect == GFX_CS);
    assign w_commit_wr = w_bus_wr && (data_address == ADDR_COMMIT);

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    gfx_state_e r_state_q;
    gfx_state_e w_state_d;
    logic       r_commit_pending_q;
    logic       r_commit_pulse_q;

    // The transfer happens only when already armed; a COMMIT arriving with
    // frame_done in IDLE just arms for the following frame.
    assign w_commit_en = (r_state_q == ST_ARMED) && frame_done;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_commit_wr) begin
                    w_state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A COMMIT in the commit cycle re-arms for the next frame
                if (frame_done && !w_commit_wr) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q          <= ST_IDLE;
            r_commit_pending_q <= 1'b0;
            r_commit_pulse_q   <= 1'b0;
        end else begin
            r_state_q          <= w_state_d;
            r_commit_pending_q <= (w_state_d == ST_ARMED);
            r_commit_pulse_q   <= w_commit_en;
        end
    end

    assign commit_pending = r_commit_pending_q;
    assign commit_pulse   = r_commit_pulse_q;

    // ------------------------------------------------------------------
    // Frame counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_frame_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count_q <= '0;
        end else if (frame_done) begin
            r_frame_count_q <= r_frame_count_q + {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    assign frame_count = r_frame_count_q;

    // ------------------------------------------------------------------
    // Object shadow/live register pairs, indexed by bus address
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_live [NUM_OBJ_REGS];

    for (genvar gi = 0; gi < NUM_OBJ_REGS; gi++) begin : g_obj_regs
        logic w_wr_en;
        assign w_wr_en = w_bus_wr && (data_address == 4'(gi));

        gfx_shadow_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (w_wr_en),
            .wr_data_i   (databus),
            .commit_en_i (w_commit_en),
            .live_o      (w_live[gi])
        );
    end

    assign paddle_1_x     = w_live[ADDR_PADDLE_1_X];
    assign paddle_1_y     = w_live[ADDR_PADDLE_1_Y];
    assign paddle_2_x     = w_live[ADDR_PADDLE_2_X];
    assign paddle_2_y     = w_live[ADDR_PADDLE_2_Y];
    assign ball_x         = w_live[ADDR_BALL_X];
    assign ball_y         = w_live[ADDR_BALL_Y];
    assign ball_z         = w_live[ADDR_BALL_Z];
    assign player_1_score = w_live[ADDR_P1_SCORE];
    assign player_2_score = w_live[ADDR_P2_SCORE];
    assign game_state     = w_live[ADDR_GAME_STATE];

endmodule : gfx_frame_regs
`default_nettype wire

// File: tb/tb_gfx_frame_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_frame_regs
// Description : Self-checking bench for gfx_frame_regs: directed vector
//               table, randomized traffic against a reference model, and the
//               frame counter wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gfx_frame_regs;

    localparam logic [3:0] C_CS = 4'd2;

    logic        clk;
    logic        rst;
    logic [3:0]  chipselect;
    logic [15:0] databus;
    logic [3:0]  data_address;
    logic        frame_done;
    logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
    logic [15:0] ball_x, ball_y, ball_z;
    logic [15:0] player_1_score, player_2_score, game_state;
    logic        commit_pending, commit_pulse;
    logic [15:0] frame_count;

    gfx_frame_regs #(
        .GFX_CS (C_CS),
        .DATA_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .chipselect     (chipselect),
        .databus        (databus),
        .data_address   (data_address),
        .frame_done     (frame_done),
        .paddle_1_x     (paddle_1_x),
        .paddle_1_y     (paddle_1_y),
        .paddle_2_x     (paddle_2_x),
        .paddle_2_y     (paddle_2_y),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_z         (ball_z),
        .player_1_score (player_1_score),
        .player_2_score (player_2_score),
        .game_state     (game_state),
        .commit_pending (commit_pending),
        .commit_pulse   (commit_pulse),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: shadow/live arrays plus an "armed" flag
    // ------------------------------------------------------------------
    logic [15:0] m_shadow [10];
    logic [15:0] m_live   [10];
    logic        m_armed;
    logic        m_pulse;
    logic [15:0] m_fc;

    task automatic model_apply(input logic r, input logic [3:0] cs,
                               input logic [3:0] addr, input logic [15:0] d,
                               input logic fd);
        logic wr, commit_wr, do_commit;
        if (r) begin
            for (int i = 0; i < 10; i++) begin
                m_shadow[i] = '0;
                m_live[i]   = '0;
            end
            m_armed = 1'b0;
            m_pulse = 1'b0;
            m_fc    = '0;
        end else begin
            wr        = (cs == C_CS);
            commit_wr = wr && (addr == 4'd15);
            do_commit = m_armed && fd;
            if (do_commit) begin
                for (int i = 0; i < 10; i++) m_live[i] = m_shadow[i];
            end
            if (wr && addr < 4'd10) m_shadow[addr] = d;
            if (commit_wr)      m_armed = 1'b1;
            else if (do_commit) m_armed = 1'b0;
            m_pulse = do_commit;
            if (fd) m_fc = m_fc + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [15:0] act [10];
        act[0] = paddle_1_x;     act[1] = paddle_1_y;
        act[2] = paddle_2_x;     act[3] = paddle_2_y;
        act[4] = ball_x;         act[5] = ball_y;
        act[6] = ball_z;         act[7] = player_1_score;
        act[8] = player_2_score; act[9] = game_state;
        for (int i = 0; i < 10; i++) chk($sformatf("live[%0d]", i), act[i], m_live[i]);
        chk("commit_pending", {15'd0, commit_pending}, {15'd0, m_armed});
        chk("commit_pulse",   {15'd0, commit_pulse},   {15'd0, m_pulse});
        chk("frame_count",    frame_count, m_fc);
    endtask

    // One clock cycle: drive at negedge, model the edge, sample 1 time unit later
    task automatic step(input logic r, input logic [3:0] cs, input logic [3:0] addr,
                        input logic [15:0] d, input logic fd, input logic do_chk);
        @(negedge clk);
        rst = r; chipselect = cs; data_address = addr; databus = d; frame_done = fd;
        @(posedge clk);
        model_apply(r, cs, addr, d, fd);
        #1;
        if (do_chk) check_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic [3:0]  cs;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        fd;
        logic [15:0] e_p1x;
        logic [15:0] e_bx;
        logic [15:0] e_by;
        logic        e_pend;
        logic        e_pulse;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(logic r, logic [3:0] cs, logic [3:0] a, logic [15:0] d,
                                logic fd, logic [15:0] p1x, logic [15:0] bx,
                                logic [15:0] by, logic pend, logic pulse, logic [15:0] fc);
        vec_t v;
        v.rst = r; v.cs = cs; v.addr = a; v.data = d; v.fd = fd;
        v.e_p1x = p1x; v.e_bx = bx; v.e_by = by;
        v.e_pend = pend; v.e_pulse = pulse; v.e_fc = fc;
        return v;
    endfunction

    initial begin
        rst = 1'b1; chipselect = 4'd0; data_address = 4'd0; databus = '0; frame_done = 1'b0;

        //            rst cs    addr   data       fd  p1x   bx    by    pnd pls fc
        tbl[0]  = mk(1, 4'd0, 4'd0,  16'h0000, 0, 0,    0,    0,    0,  0,  0);
        tbl[1]  = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    0,    0,    0,  0,  1);
        tbl[2]  = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    0,    0,    0,  0,  2);
        tbl[3]  = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    0,    0,    0,  0,  3);
        tbl[4]  = mk(0, C_CS, 4'd4,  16'd320,  0, 0,    0,    0,    0,  0,  3);
        tbl[5]  = mk(0, C_CS, 4'd5,  16'd240,  0, 0,    0,    0,    0,  0,  3);
        tbl[6]  = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    0,    0,    0,  0,  4);
        tbl[7]  = mk(0, C_CS, 4'd15, 16'h0000, 0, 0,    0,    0,    1,  0,  4);
        tbl[8]  = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    320,  240,  0,  1,  5);
        tbl[9]  = mk(0, C_CS, 4'd4,  16'd7,    0, 0,    320,  240,  0,  0,  5);
        tbl[10] = mk(0, C_CS, 4'd15, 16'h0000, 1, 0,    320,  240,  1,  0,  6);
        tbl[11] = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    7,    240,  0,  1,  7);
        tbl[12] = mk(0, C_CS, 4'd0,  16'd50,   0, 0,    7,    240,  0,  0,  7);
        tbl[13] = mk(0, C_CS, 4'd15, 16'h0000, 0, 0,    7,    240,  1,  0,  7);
        tbl[14] = mk(0, C_CS, 4'd0,  16'd100,  1, 50,   7,    240,  0,  1,  8);
        tbl[15] = mk(0, C_CS, 4'd15, 16'h0000, 0, 50,   7,    240,  1,  0,  8);
        tbl[16] = mk(0, 4'd0, 4'd0,  16'h0000, 1, 100,  7,    240,  0,  1,  9);
        tbl[17] = mk(0, C_CS, 4'd10, 16'hFFFF, 0, 100,  7,    240,  0,  0,  9);
        tbl[18] = mk(0, C_CS, 4'd14, 16'hFFFF, 0, 100,  7,    240,  0,  0,  9);
        tbl[19] = mk(0, 4'd3, 4'd0,  16'h1234, 0, 100,  7,    240,  0,  0,  9);
        tbl[20] = mk(0, C_CS, 4'd15, 16'hFFFF, 0, 100,  7,    240,  1,  0,  9);
        tbl[21] = mk(0, 4'd0, 4'd0,  16'h0000, 1, 100,  7,    240,  0,  1,  10);
        tbl[22] = mk(0, C_CS, 4'd15, 16'h0000, 0, 100,  7,    240,  1,  0,  10);
        tbl[23] = mk(1, C_CS, 4'd15, 16'h0000, 1, 0,    0,    0,    0,  0,  0);
        tbl[24] = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    0,    0,    0,  0,  1);
        tbl[25] = mk(0, C_CS, 4'd4,  16'd9,    0, 0,    0,    0,    0,  0,  1);
        tbl[26] = mk(0, C_CS, 4'd15, 16'h0000, 0, 0,    0,    0,    1,  0,  1);
        tbl[27] = mk(0, C_CS, 4'd15, 16'h0000, 1, 0,    9,    0,    1,  1,  2);
        tbl[28] = mk(0, 4'd0, 4'd0,  16'h0000, 1, 0,    9,    0,    0,  1,  3);

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].rst, tbl[i].cs, tbl[i].addr, tbl[i].data, tbl[i].fd, 1'b1);
            chk($sformatf("vec%0d paddle_1_x", i), paddle_1_x, tbl[i].e_p1x);
            chk($sformatf("vec%0d ball_x", i),     ball_x,     tbl[i].e_bx);
            chk($sformatf("vec%0d ball_y", i),     ball_y,     tbl[i].e_by);
            chk($sformatf("vec%0d pending", i),    {15'd0, commit_pending}, {15'd0, tbl[i].e_pend});
            chk($sformatf("vec%0d pulse", i),      {15'd0, commit_pulse},   {15'd0, tbl[i].e_pulse});
            chk($sformatf("vec%0d frame_count", i), frame_count, tbl[i].e_fc);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic       r_r, r_fd;
            logic [3:0] r_cs, r_addr;
            r_r    = ($urandom_range(0, 199) == 0);
            r_cs   = ($urandom_range(0, 3) != 0) ? C_CS : 4'($urandom_range(0, 15));
            r_addr = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            r_fd   = ($urandom_range(0, 3) == 0);
            step(r_r, r_cs, r_addr, 16'($urandom), r_fd, 1'b1);
        end

        // Frame counter wrap: 65535 pulses reach FFFF, one more wraps to 0
        step(1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        for (int n = 0; n < 65535; n++) step(1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        chk("frame_count at FFFF", frame_count, 16'hFFFF);
        step(1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1);
        chk("frame_count wrap", frame_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_gfx_frame_regs
`default_nettype wire

// File: doc/gfx_frame_regs.md
# gfx_frame_regs

Bus-side register bank and frame-synchronous commit controller for the graphics ASIC. Captures CPU writes for the object parameters into shadow registers:
- paddle positions
- ball position
- scores
- game state

On a CPU commit request, it transfers all shadow values to the live registers in a single cycle at the next end-of-frame strobe. The live registers feed the Paddle_1, Paddle_2, Ball and Frame_Score renderers, so no frame is ever drawn with a mix of old and new object state.

## Interface
Parameters:
- GFX_CS, 4'd2, chipselect value that addresses this block
- DATA_W, 16, width of every register and of databus

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- chipselect  in  4  bus select; a write occurs on any cycle with chipselect == GFX_CS
- databus  in  DATA_W  write data
- data_address  in  4  register index
- frame_done  in  1  one-cycle pulse from Control after the last pixel of a frame
- paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y  out  DATA_W each  live paddle positions
- ball_x, ball_y, ball_z  out  DATA_W each  live ball position
- player_1_score, player_2_score  out  DATA_W each  live scores
- game_state  out  DATA_W  live game state
- commit_pending  out  1  high while a commit is armed (state ARMED)
- commit_pulse  out  1  one-cycle pulse in the cycle after a commit edge
- frame_count  out  DATA_W  frames seen since reset; wraps

## Operation
- Address map:
  - 0 paddle_1_x
  - 1 paddle_1_y
  - 2 paddle_2_x
  - 3 paddle_2_y
  - 4 ball_x
  - 5 ball_y
  - 6 ball_z
  - 7 player_1_score
  - 8 player_2_score
  - 9 game_state
  - 10–14 reserved: write ignored, no side effect
  - 15 COMMIT: data ignored, arms a commit
- Writes to addresses 0–9 update only the shadow register. They are accepted in every state, with no stall.
- FSM states: IDLE, ARMED.
  - IDLE: a COMMIT write moves to ARMED, including in a cycle where frame_done is also high; no commit happens that frame.
  - ARMED, frame_done low: stay in ARMED; a further COMMIT write changes nothing.
  - ARMED, frame_done high: copy all ten shadow registers to the live registers.
    - Next state is ARMED if a COMMIT write occurs in the same cycle, otherwise IDLE.
- The commit copies the shadow contents as they stood before the edge. A data write in the commit cycle lands in the shadow only and is carried by the next commit.
- In IDLE, frame_done does not touch the live registers.
- frame_count increments by 1 on every frame_done, in any state, and wraps from 16'hFFFF to 0.
- Reset: FSM to IDLE; all shadow registers, live registers and frame_count to 0; commit_pending = 0; commit_pulse = 0.
- Reset has priority over every other input. A reset in ARMED discards the pending commit.

## Timing
- All state changes on the rising edge of clk; no combinational path from inputs to outputs.
- A shadow write at edge N is visible to a commit at edge N+1 or later.
- commit_pending rises the cycle after the COMMIT write edge.
- Live outputs change the cycle after the edge at which frame_done is sampled in ARMED; commit_pulse is high for that same single cycle.
- frame_count updates one cycle after frame_done is sampled.
- Back-to-back frame_done pulses on consecutive cycles are legal; each is evaluated independently.

## Structure
- Shared package `gfx_pkg`:
  - address constants ADDR_PADDLE_1_X … ADDR_GAME_STATE and ADDR_COMMIT
  - NUM_OBJ_REGS = 10
  - the FSM state encoding
  - default GFX_CS
- Sub-module `gfx_shadow_reg`: one DATA_W shadow/live pair with write-enable, commit-enable and synchronous reset, instantiated ten times.
- The top level holds the address decode, the FSM and the frame counter.

## Test plan
- Reset, then frame_done ×3 with no writes → all live outputs 0, commit_pending 0, frame_count = 3.
- Write ball_x = 16'd320, ball_y = 16'd240, then frame_done with no COMMIT → live ball_x/ball_y remain 0. Then COMMIT followed by frame_done → ball_x = 320, ball_y = 240 one cycle later, with commit_pulse high for exactly 1 cycle.
- COMMIT write in the same cycle as frame_done from IDLE → no update that frame; the update happens on the following frame_done.
- In ARMED, write paddle_1_x = 16'd100 in the frame_done cycle (shadow previously 16'd50) → live paddle_1_x = 50. The value 100 appears only after a second COMMIT plus frame_done.
- Writes to addresses 10–14, and writes with chipselect ≠ GFX_CS, followed by COMMIT and frame_done → every live register unchanged.
- Arm a commit, assert rst for 1 cycle, then frame_done → no commit_pulse, all outputs 0. Separately, preload frame_count to 16'hFFFF via 65535 frame_done pulses; one more pulse → frame_count = 0.
